gelu_ratio_unit: RTL and testbench

Sequential stage downstream of the exponent unit in the GELU datapath. It takes the exponent unit's Q48.16 result E = 2^s(x), together with the original activation x in Q10.22. It forms the sigmoid-style ratio r = E/(E+1) with a radix-2 restoring divider, then returns GELU(x) ≈ x·r in Q10.22. Transfers on both sides use valid/ready handshakes, and the block processes one element at a time.

---
 rtl/gelu_ratio_unit.sv | 137 +++++++++++++
 tb/tb_gelu_ratio_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/gelu_ratio_unit.sv
// GELU ratio stage: r = E/(E+1) by radix-2 restoring division, then gelu = x*r in Q10.22.
// One element at a time, valid/ready on both sides.
module gelu_ratio_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned Q_IN   = 22,
    parameter int unsigned Q_EXP  = 16,
    parameter int unsigned R_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x_in,
    input  logic [2*WIDTH-1:0]   exp_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     gelu_out,
    output logic                 busy
);

    localparam int unsigned REM_W  = 2 * WIDTH + 1;
    localparam int unsigned PROD_W = WIDTH + R_BITS + 1;
    localparam int unsigned CNT_W  = $clog2(R_BITS);
    localparam logic [REM_W-1:0] E_ONE = REM_W'(1) << Q_EXP;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_MUL,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]  x_reg;
    logic [REM_W-1:0]  rem;
    logic [REM_W-1:0]  den;
    logic [R_BITS-1:0] q;
    logic [CNT_W-1:0]  cnt;

    logic [REM_W-1:0]  e_ld;
    logic [REM_W-1:0]  rem_sh;
    logic [REM_W-1:0]  rem_nxt;
    logic              q_bit;
    logic              div_last;
    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] q_ext;
    logic signed [PROD_W-1:0] prod;
    logic              unused_bits;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign div_last = (cnt == CNT_W'(R_BITS - 1));

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_DIV;
            ST_DIV:  if (div_last)  state_nxt = ST_MUL;
            ST_MUL:                 state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Handshake/status decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Negative exponent results clamp to zero; extra MSB keeps E+1 from overflowing
    assign e_ld = exp_in[2*WIDTH-1] ? '0 : {1'b0, exp_in};

    // Restoring division step; rem < den always, so the shifted MSB is never set
    assign rem_sh  = {rem[REM_W-2:0], 1'b0};
    assign q_bit   = (rem_sh >= den);
    assign rem_nxt = q_bit ? (rem_sh - den) : rem_sh;

    // Signed x times unsigned ratio; the slice is the arithmetic shift by R_BITS
    assign x_ext = {{(R_BITS + 1){x_reg[WIDTH-1]}}, x_reg};
    assign q_ext = {{(WIDTH + 1){1'b0}}, q};
    assign prod  = x_ext * q_ext;

    assign unused_bits = ^{prod[R_BITS-1:0], prod[PROD_W-1], rem[REM_W-1], 32'(Q_IN)};

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg    <= '0;
            rem      <= '0;
            den      <= '0;
            q        <= '0;
            cnt      <= '0;
            gelu_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_reg <= x_in;
                        rem   <= e_ld;
                        den   <= e_ld + E_ONE;
                        q     <= '0;
                        cnt   <= '0;
                    end
                end
                ST_DIV: begin
                    rem <= rem_nxt;
                    q   <= {q[R_BITS-2:0], q_bit};
                    cnt <= cnt + CNT_W'(1);
                end
                ST_MUL: begin
                    gelu_out <= prod[R_BITS +: WIDTH];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gelu_ratio_unit.sv
// Self-checking bench for gelu_ratio_unit: directed edge cases, backpressure,
// mid-division reset and a random sweep against an arithmetic reference model.
module tb_gelu_ratio_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in;
    logic [63:0] exp_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] gelu_out;
    logic        busy;

    int n_tests;
    int n_fail;

    gelu_ratio_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gelu_out  (gelu_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // GELU ~= floor(x * floor(2^16*E/(E+2^16)) / 2^16), with negative E treated as 0
    function automatic logic [31:0] model(input logic [31:0] x, input logic [63:0] e);
        logic [127:0] ee;
        logic [127:0] qq;
        longint       sx;
        longint       qv;
        longint       p;
        ee = e[63] ? 128'd0 : {64'd0, e};
        qq = (ee << 16) / (ee + 128'd65536);
        sx = longint'($signed(x));
        qv = longint'(qq[63:0]);
        p  = (sx * qv) >>> 16;
        return p[31:0];
    endfunction

    // One full transaction: accept, latency check, result, hold for 'hold' cycles, transfer
    task automatic run_txn(input logic [31:0] x, input logic [63:0] e, input int hold,
                           input string tag);
        int          k;
        logic [31:0] exp_v;
        exp_v = model(x, e);
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        x_in      = x;
        exp_in    = e;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        x_in     = $urandom;
        exp_in   = {$urandom, $urandom};
        check({tag, "_busy"}, {62'd0, busy, in_ready}, 64'b10);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'd17);
        check({tag, "_val"}, 64'(gelu_out), 64'(exp_v));
        for (int i = 0; i < hold; i++) begin
            in_valid = $urandom_range(0, 1) == 1;
            x_in     = $urandom;
            exp_in   = {$urandom, $urandom};
            @(negedge clk);
            check({tag, "_hold"}, {30'd0, out_valid, in_ready, gelu_out}, {30'd0, 2'b10, exp_v});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_xfer"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        exp_in    = '0;
        #23;
        check("rst_state", {28'd0, out_valid, busy, in_ready, 1'b0, gelu_out},
              {28'd0, 4'b0010, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived expectations alongside the model
        check("dir_model_a", 64'(model(32'h0040_0000, 64'h1_0000)), 64'h0020_0000);
        run_txn(32'h0040_0000, 64'h1_0000, 0, "one_one");
        check("dir_model_b", 64'(model(32'h0080_0000, 64'h3_0000)), 64'h0060_0000);
        run_txn(32'h0080_0000, 64'h3_0000, 1, "two_three");
        check("dir_model_c", 64'(model(32'hFFC0_0000, 64'h3_0000)), 64'hFFD0_0000);
        run_txn(32'hFFC0_0000, 64'h3_0000, 0, "neg_three");
        check("dir_model_d", 64'(model(32'h0040_0000, 64'h7FFF_FFFF_FFFF_FFFF)), 64'h003F_FFC0);
        run_txn(32'h0040_0000, 64'h7FFF_FFFF_FFFF_FFFF, 0, "e_max");
        run_txn(32'hFFC0_0000, 64'h0, 0, "e_zero");
        run_txn(32'h0040_0000, 64'h8000_0000_0000_0000, 0, "e_neg");
        run_txn(32'h0, 64'h3_0000, 0, "x_zero");
        run_txn(32'h0080_0000, 64'h3_0000, 5, "bkpr");

        // Reset eight cycles into the division
        x_in     = 32'h0040_0000;
        exp_in   = 64'h3_0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst", {28'd0, out_valid, busy, in_ready, 1'b0, gelu_out},
              {28'd0, 4'b0010, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("no_stale", 64'(out_valid), 64'd0);
        end
        run_txn(32'h0040_0000, 64'h1_0000, 0, "post_rst");

        // Random sweep
        for (int t = 0; t < 1000; t++) begin
            logic [31:0] rx;
            logic [63:0] re;
            rx = $urandom;
            re = {$urandom, $urandom} % ((64'd1 << 46) + 64'd1);
            run_txn(rx, re, $urandom_range(0, 3), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
